// File: rtl/aer_event_arbiter.sv
// Round-robin arbiter that shares one AER Sender between NUM_CH Up/Down event channels.
// Per-channel capture slices hold pending events; a GO/WAIT/GAP sequencer drives the Sender.

module aer_ch_capture (
  input  logic clk,
  input  logic reset,
  input  logic ev_up,
  input  logic ev_down,
  input  logic clr_up,
  input  logic clr_dn,
  input  logic ovf_clr,
  output logic pend_up,
  output logic pend_dn,
  output logic overflow
);
  logic drop;

  // An event only drops when it lands on a pend bit that is not leaving this cycle.
  assign drop = (ev_up & pend_up & ~clr_up) | (ev_down & pend_dn & ~clr_dn);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_up  <= 1'b0;
      pend_dn  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pend_up  <= ev_up   | (pend_up & ~clr_up);
      pend_dn  <= ev_down | (pend_dn & ~clr_dn);
      overflow <= drop    | (overflow & ~ovf_clr);
    end
  end
endmodule

module aer_event_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int TIMEOUT_CYC = 1023,
  parameter int GAP_CYC     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ev_up,
  input  logic [NUM_CH-1:0] ev_down,
  input  logic              ovf_clr,
  input  logic              snd_done,
  output logic              snd_go,
  output logic [NUM_CH-1:0] snd_ch,
  output logic              snd_up,
  output logic              snd_down,
  output logic [NUM_CH-1:0] overflow,
  output logic              timeout_err,
  output logic [15:0]       sent_count
);
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {IDLE, GO, WAIT, GAP} state_t;

  state_t            state, state_nx;
  logic [NUM_CH-1:0] pend_up, pend_dn, req, clr_up, clr_dn;
  logic [CW-1:0]     rr_ptr, sel_ch, pick, ch_nx;
  logic              sel_up, dir_nx, found, arb_take, wait_done, wait_to, active_nx;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  int                j;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    aer_ch_capture u_cap (
      .clk      (clk),
      .reset    (reset),
      .ev_up    (ev_up[i]),
      .ev_down  (ev_down[i]),
      .clr_up   (clr_up[i]),
      .clr_dn   (clr_dn[i]),
      .ovf_clr  (ovf_clr),
      .pend_up  (pend_up[i]),
      .pend_dn  (pend_dn[i]),
      .overflow (overflow[i])
    );
  end

  assign req = pend_up | pend_dn;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      j = (int'(rr_ptr) + k) % NUM_CH;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = CW'(j);
      end
    end
  end

  // The last GAP cycle doubles as an arbitration slot, so frames start GAP_CYC+2 cycles apart.
  always_comb begin
    state_nx  = state;
    arb_take  = 1'b0;
    wait_done = 1'b0;
    wait_to   = 1'b0;
    case (state)
      IDLE: if (found) begin
        state_nx = GO;
        arb_take = 1'b1;
      end
      GO:   state_nx = WAIT;
      WAIT: if (snd_done) begin
        state_nx  = GAP;
        wait_done = 1'b1;
      end else if (timer == TW'(TIMEOUT_CYC - 1)) begin
        state_nx = GAP;
        wait_to  = 1'b1;
      end
      GAP:  if (gap_cnt == GW'(GAP_CYC - 1)) begin
        if (found) begin
          state_nx = GO;
          arb_take = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clr_up = '0;
    clr_dn = '0;
    if (arb_take) begin
      clr_up[pick] = pend_up[pick];
      clr_dn[pick] = ~pend_up[pick];
    end
  end

  assign ch_nx     = arb_take ? pick : sel_ch;
  assign dir_nx    = arb_take ? pend_up[pick] : sel_up;
  assign active_nx = (state_nx == GO) || (state_nx == WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_ch      <= '0;
      sel_up      <= 1'b0;
      rr_ptr      <= '0;
      timer       <= '0;
      gap_cnt     <= '0;
      snd_go      <= 1'b0;
      snd_ch      <= '0;
      snd_up      <= 1'b0;
      snd_down    <= 1'b0;
      timeout_err <= 1'b0;
      sent_count  <= '0;
    end else begin
      state <= state_nx;
      if (arb_take) begin
        sel_ch <= pick;
        sel_up <= pend_up[pick];
      end
      if (state == GO)        timer <= '0;
      else if (state == WAIT) timer <= timer + 1'b1;
      gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
      if (wait_done || wait_to)
        rr_ptr <= (sel_ch == CW'(NUM_CH - 1)) ? '0 : sel_ch + 1'b1;
      if (wait_done) sent_count <= sent_count + 16'd1;
      if (wait_to)      timeout_err <= 1'b1;
      else if (ovf_clr) timeout_err <= 1'b0;
      snd_go   <= (state_nx == GO);
      snd_ch   <= active_nx ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_nx) : '0;
      snd_up   <= active_nx & dir_nx;
      snd_down <= active_nx & ~dir_nx;
    end
  end
endmodule

// File: tb/tb_aer_event_arbiter.sv
// Randomized and directed bench for aer_event_arbiter against a timestamp-based frame model.
// The bench plays the Sender; every cycle all outputs are compared to the model.

module tb_aer_event_arbiter;
  localparam int N   = 2;
  localparam int TO  = 15;
  localparam int GAP = 2;

  logic         clk = 1'b0, reset = 1'b1;
  logic [N-1:0] ev_up = '0, ev_down = '0;
  logic         ovf_clr = 1'b0, snd_done = 1'b0;
  logic         snd_go, snd_up, snd_down, timeout_err;
  logic [N-1:0] snd_ch, overflow;
  logic [15:0]  sent_count;

  always #5 clk = ~clk;

  aer_event_arbiter #(.NUM_CH(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)) dut (
    .clk(clk), .reset(reset), .ev_up(ev_up), .ev_down(ev_down), .ovf_clr(ovf_clr),
    .snd_done(snd_done), .snd_go(snd_go), .snd_ch(snd_ch), .snd_up(snd_up),
    .snd_down(snd_down), .overflow(overflow), .timeout_err(timeout_err),
    .sent_count(sent_count)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: pending sets plus the timestamps of the frame in flight.
  bit m_pu[N], m_pd[N], m_ovf[N];
  bit m_terr, m_busy, m_up;
  int m_cnt, m_rr, m_go, m_ch, m_arb_ok, cyc;
  int done_mode, done_dly;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_pu[i] = 0; m_pd[i] = 0; m_ovf[i] = 0;
    end
    m_terr = 0; m_busy = 0; m_up = 0;
    m_cnt = 0; m_rr = 0; m_go = 0; m_ch = 0; m_arb_ok = 0;
  endfunction

  function automatic void model_update(logic [N-1:0] u, logic [N-1:0] d, logic c, logic dn);
    bit cu[N], cd[N];
    bit ended = 0, set_to = 0, drop;
    for (int i = 0; i < N; i++) begin cu[i] = 0; cd[i] = 0; end
    if (!m_busy && cyc >= m_arb_ok) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (!m_busy && (m_pu[i] || m_pd[i])) begin
          m_busy = 1; m_go = cyc + 1; m_ch = i; m_up = m_pu[i];
          if (m_pu[i]) cu[i] = 1; else cd[i] = 1;
        end
      end
    end else if (m_busy && cyc > m_go) begin
      if (dn) begin m_cnt++; ended = 1; end
      else if (cyc - m_go == TO) begin set_to = 1; ended = 1; end
    end
    if (ended) begin
      m_busy = 0; m_arb_ok = cyc + GAP; m_rr = (m_ch + 1) % N;
    end
    if (set_to) m_terr = 1; else if (c) m_terr = 0;
    for (int i = 0; i < N; i++) begin
      drop = (u[i] && m_pu[i] && !cu[i]) || (d[i] && m_pd[i] && !cd[i]);
      m_pu[i]  = u[i] || (m_pu[i] && !cu[i]);
      m_pd[i]  = d[i] || (m_pd[i] && !cd[i]);
      m_ovf[i] = drop || (m_ovf[i] && !c);
    end
  endfunction

  task automatic check_outputs();
    logic [N-1:0] e_ch, e_ovf;
    e_ch = '0;
    e_ovf = '0;
    if (m_busy) e_ch[m_ch] = 1'b1;
    for (int i = 0; i < N; i++) e_ovf[i] = m_ovf[i];
    chk("snd_go",      32'(snd_go),      32'(m_busy && cyc == m_go));
    chk("snd_ch",      32'(snd_ch),      32'(e_ch));
    chk("snd_up",      32'(snd_up),      32'(m_busy && m_up));
    chk("snd_down",    32'(snd_down),    32'(m_busy && !m_up));
    chk("overflow",    32'(overflow),    32'(e_ovf));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("sent_count",  32'(sent_count),  m_cnt & 32'hFFFF);
  endtask

  task automatic step(input logic [N-1:0] u, input logic [N-1:0] d, input logic c);
    logic dn;
    @(negedge clk);
    check_outputs();
    case (done_mode)
      1:       dn = m_busy && cyc > m_go && (cyc - m_go == done_dly);
      2:       dn = ($urandom_range(5) == 0);
      default: dn = 1'b0;
    endcase
    ev_up = u; ev_down = d; ovf_clr = c; snd_done = dn;
    @(posedge clk);
    model_update(u, d, c, dn);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, '0, 1'b0);
  endtask

  int saved;

  initial begin
    cyc = 0; done_mode = 1; done_dly = 3;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_go", 32'(snd_go), 0);
    chk("rst_ch", 32'(snd_ch), 0);
    chk("rst_cnt", 32'(sent_count), 0);
    @(negedge clk);
    reset = 1'b0;

    // single Up event on ch0: GO two cycles after the pulse
    step(2'b01, 2'b00, 1'b0);
    step('0, '0, 1'b0);
    #1;
    chk("t1_go", 32'(snd_go), 1);
    chk("t1_ch", 32'(snd_ch), 32'h1);
    idle(12);
    chk("t1_cnt", 32'(sent_count), 1);

    // simultaneous requests, round-robin order
    step(2'b11, 2'b00, 1'b0); idle(20);
    step(2'b11, 2'b00, 1'b0); idle(20);
    step(2'b01, 2'b00, 1'b0); idle(12);
    step(2'b11, 2'b00, 1'b0); idle(20);

    // Up and Down on ch1 together: two frames, no overflow
    step(2'b10, 2'b10, 1'b0); idle(20);
    #1 chk("t3_ovf", 32'(overflow), 0);

    // double Down on ch1 while ch0 is in flight
    done_dly = 8;
    step(2'b01, 2'b00, 1'b0); idle(3);
    step('0, 2'b10, 1'b0); step('0, '0, 1'b0); step('0, 2'b10, 1'b0);
    idle(25);
    #1 chk("t4_ovf", 32'(overflow), 32'h2);
    step('0, '0, 1'b1); idle(1);
    #1 chk("t4_clr", 32'(overflow), 0);

    // timeout with no done, then normal service resumes
    saved = int'(sent_count);
    done_mode = 0;
    step(2'b01, 2'b00, 1'b0); idle(25);
    #1 chk("t5_terr", 32'(timeout_err), 1);
    chk("t5_cnt", 32'(sent_count), 32'(saved));
    done_mode = 1; done_dly = 2;
    step(2'b10, 2'b00, 1'b0); idle(15);
    #1 chk("t5_next", 32'(sent_count), 32'(saved + 1));
    step('0, '0, 1'b1); idle(2);

    // random traffic with a random Sender
    done_mode = 2;
    repeat (3000) begin
      logic [N-1:0] u, d;
      u = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      d = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      step(u, d, ($urandom_range(60) == 0));
    end
    done_mode = 1; done_dly = 1;
    idle(40);

    // async reset in the middle of WAIT drops everything at once
    done_mode = 0;
    step(2'b01, 2'b00, 1'b0); step('0, '0, 1'b0); step('0, '0, 1'b0);
    step('0, 2'b10, 1'b0); step('0, '0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_go", 32'(snd_go), 0);
    chk("t6_ch", 32'(snd_ch), 0);
    chk("t6_up", 32'(snd_up), 0);
    chk("t6_cnt", 32'(sent_count), 0);
    m_reset();
    ev_up = '0; ev_down = '0; ovf_clr = 1'b0; snd_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    done_mode = 1; done_dly = 3;
    step(2'b01, 2'b00, 1'b0);
    step('0, '0, 1'b0);
    #1 chk("t6_go2", 32'(snd_go), 1);
    idle(12);
    chk("t6_cnt2", 32'(sent_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
